// File: rtl/rf_wb_arbiter.sv
// ---------------------------------------------------------------------------
// rf_wb_arbiter
//
// Purpose:
//   This block arbitrates register-file write-back among three requesters
//   (0 = ALU, 1 = load, 2 = debug). It uses round-robin priority. The
//   winning request is registered and presented to the register file one
//   cycle later.
//
//   A write to register 0 is accepted but never reaches the register file.
//   Such a write bumps a saturating drop counter instead.
//
// Ports:
//   clock            in   rising-edge clock
//   reset            in   synchronous, active-high reset
//   req_valid[2:0]   in   per-requester write request
//   req_addr[14:0]   in   packed 5-bit destination addresses, req i at [5i+:5]
//   req_data[95:0]   in   packed 32-bit write values, req i at [32i+:32]
//   req_ready[2:0]   out  combinational accept (one-hot or zero)
//   stall            in   blocks all acceptance while high
//   rf_write_enabled out  registered write enable
//   rf_write_addr    out  registered write address
//   rf_write_data    out  registered write data
//   drop_count       out  saturating count of accepted writes to register 0
// ---------------------------------------------------------------------------
module rf_wb_arbiter #(
  parameter int DROP_CNT_W = 8
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [2:0]            req_valid,
  input  logic [14:0]           req_addr,
  input  logic [95:0]           req_data,
  output logic [2:0]            req_ready,
  input  logic                  stall,
  output logic                  rf_write_enabled,
  output logic [4:0]            rf_write_addr,
  output logic [31:0]           rf_write_data,
  output logic [DROP_CNT_W-1:0] drop_count
);

  localparam int NUM_REQ = 3;

  // Architectural state
  logic [1:0]            last_grant_reg, last_grant_next;
  logic                  wr_en_reg, wr_en_next;
  logic [4:0]            wr_addr_reg, wr_addr_next;
  logic [31:0]           wr_data_reg, wr_data_next;
  logic [DROP_CNT_W-1:0] drop_cnt_reg, drop_cnt_next;

  // Unpacked request fields and round-robin candidate order
  logic [4:0]  req_addr_arr [NUM_REQ];
  logic [31:0] req_data_arr [NUM_REQ];
  logic [1:0]  cand_idx     [NUM_REQ];
  logic [1:0]  rr_start;

  logic        grant_found;
  logic [1:0]  grant_idx;
  logic        transfer;
  logic [4:0]  sel_addr;
  logic [31:0] sel_data;

  // The search begins one past the last winner. last_grant only ever holds
  // 0..2, so the value 3 falls back to requester 0 for safety.
  always_comb begin
    rr_start = 2'd0;
    case (last_grant_reg)
      2'd0:    rr_start = 2'd1;
      2'd1:    rr_start = 2'd2;
      default: rr_start = 2'd0;
    endcase
  end

  genvar gi;
  generate
    for (gi = 0; gi < NUM_REQ; gi++) begin : g_req
      logic [2:0] cand_sum;

      assign req_addr_arr[gi] = req_addr[5*gi +: 5];
      assign req_data_arr[gi] = req_data[32*gi +: 32];

      // Candidate gi is (rr_start + gi) mod 3
      assign cand_sum     = {1'b0, rr_start} + 3'(gi);
      assign cand_idx[gi] = (cand_sum >= 3'd3) ? 2'(cand_sum - 3'd3)
                                               : cand_sum[1:0];

      // The accept path depends only on inputs and last_grant. It never
      // depends on the rf_* registers.
      assign req_ready[gi] = transfer && (grant_idx == 2'(gi));
    end
  endgenerate

  // The first valid requester in round-robin order wins.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = 2'd0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (!grant_found && req_valid[cand_idx[k]]) begin
        grant_found = 1'b1;
        grant_idx   = cand_idx[k];
      end
    end
  end

  // Reset and stall both block acceptance.
  assign transfer = grant_found && !stall && !reset;
  assign sel_addr = req_addr_arr[grant_idx];
  assign sel_data = req_data_arr[grant_idx];

  always_comb begin
    last_grant_next = last_grant_reg;
    wr_en_next      = 1'b0;
    wr_addr_next    = wr_addr_reg;
    wr_data_next    = wr_data_reg;
    drop_cnt_next   = drop_cnt_reg;

    if (transfer) begin
      last_grant_next = grant_idx;
      if (sel_addr != 5'd0) begin
        wr_en_next   = 1'b1;
        wr_addr_next = sel_addr;
        wr_data_next = sel_data;
      end else if (drop_cnt_reg != {DROP_CNT_W{1'b1}}) begin
        // A write to register 0 is swallowed. It is counted, and the count
        // saturates.
        drop_cnt_next = drop_cnt_reg + DROP_CNT_W'(1);
      end
    end
  end

  // last_grant resets to 2 so that requester 0 has first priority.
  always_ff @(posedge clock) begin
    if (reset) begin
      last_grant_reg <= 2'd2;
      wr_en_reg      <= 1'b0;
      wr_addr_reg    <= 5'd0;
      wr_data_reg    <= 32'd0;
      drop_cnt_reg   <= '0;
    end else begin
      last_grant_reg <= last_grant_next;
      wr_en_reg      <= wr_en_next;
      wr_addr_reg    <= wr_addr_next;
      wr_data_reg    <= wr_data_next;
      drop_cnt_reg   <= drop_cnt_next;
    end
  end

  assign rf_write_enabled = wr_en_reg;
  assign rf_write_addr    = wr_addr_reg;
  assign rf_write_data    = wr_data_reg;
  assign drop_count       = drop_cnt_reg;

endmodule

// File: doc/rf_wb_arbiter.md
RF_WB_ARBITER -- requirements
Module: rf_wb_arbiter

Interface
REQ-001 The module SHALL have parameter DROP_CNT_W, default 8: width of the dropped-write counter.
REQ-002 The module SHALL have port clock, input, 1: clock; all state changes on its rising edge.
REQ-003 The module SHALL have port reset, input, 1: synchronous, active-high reset.
REQ-004 The module SHALL have port req_valid, input, 3: per-requester write request (bit 0 = ALU, bit 1 = load, bit 2 = debug).
REQ-005 The module SHALL have port req_addr, input, 15: three packed 5-bit destination register addresses; requester i uses bits [5i+4:5i].
REQ-006 The module SHALL have port req_data, input, 96: three packed 32-bit write values; requester i uses bits [32i+31:32i].
REQ-007 The module SHALL have port req_ready, output, 3: per-requester accept indication, combinational.
REQ-008 The module SHALL have port stall, input, 1: when high, no request is accepted.
REQ-009 The module SHALL have port rf_write_enabled, output, 1: registered write enable to the register file.
REQ-010 The module SHALL have port rf_write_addr, output, 5: registered write address.
REQ-011 The module SHALL have port rf_write_data, output, 32: registered write data.
REQ-012 The module SHALL have port drop_count, output, DROP_CNT_W: saturating count of accepted writes to register 0.

Function
REQ-013 A transfer from requester i SHALL occur on a rising edge where req_valid[i] and req_ready[i] are both high.
REQ-014 At most one req_ready bit SHALL be high in any cycle.
REQ-015 req_ready[i] SHALL be high only when stall is low, req_valid[i] is high, and i is the first valid requester in round-robin order.
REQ-016 Round-robin order SHALL start at the requester after last_grant and wrap modulo 3.
REQ-017 last_grant SHALL update to i on every transfer from requester i and hold otherwise.
REQ-018 req_ready SHALL NOT depend combinationally on any rf_* output.
REQ-019 A requester SHALL hold valid, addr and data stable until its transfer; the arbiter does not buffer unaccepted requests.
REQ-020 A transfer with nonzero address SHALL set, on the same edge, rf_write_enabled=1, rf_write_addr=req_addr[i], rf_write_data=req_data[i]. Latency is one cycle; the register file commits on the following edge.
REQ-021 A transfer with address 0 SHALL be accepted (req_ready high) and SHALL set rf_write_enabled=0. drop_count SHALL increment by 1 and saturate at all-ones.
REQ-022 In a cycle with no transfer, rf_write_enabled SHALL be 0 on the next edge; rf_write_addr and rf_write_data SHALL hold.
REQ-023 With stall low, a continuously valid requester SHALL be granted within 3 cycles of raising valid.
REQ-024 When two requesters target the same address in one cycle, only the granted one SHALL be written; the other SHALL wait for its own grant.
REQ-025 Stall asserted mid-sequence SHALL suppress grants from that cycle. Any write already registered SHALL still be presented for its one cycle.

Reset
REQ-026 On a rising edge with reset high, the following SHALL be set: rf_write_enabled=0, rf_write_addr=0, rf_write_data=0, drop_count=0, last_grant=2 (so requester 0 has first priority).
REQ-027 While reset is high, req_ready SHALL be 0 and no transfer SHALL occur. Reset SHALL take priority over any simultaneous request.
REQ-028 A reset asserted in the cycle after a transfer SHALL clear rf_write_enabled on that edge, cancelling the pending write.

Verification
REQ-029 After reset, all three requesters valid, stall=0, addresses 1, 2, 3 with data A1, B2, C3 -> grants in order 0, 1, 2 on three consecutive edges. rf_write_enabled is high for three consecutive cycles with (1,A1), (2,B2), (3,C3).
REQ-030 Requester 1 valid continuously, addr 5, while requesters 0 and 2 are each re-requesting -> requester 1 is granted within 3 cycles, and every 3 cycles thereafter.
REQ-031 Requester 0 writes addr 0, data FFFFFFFF -> req_ready[0]=1, rf_write_enabled stays 0, drop_count increments to 1. With DROP_CNT_W=2, 4 further zero writes -> drop_count holds at 3.
REQ-032 stall=1 for 4 cycles with all requesters valid -> req_ready=000 and rf_write_enabled=0 throughout. After stall drops, the grant resumes from the round-robin position.
REQ-033 Reset asserted on the edge after a transfer to addr 7 -> rf_write_enabled=0, outputs are zero, and the next grant goes to requester 0.
REQ-034 Requesters 0 and 2 target addr 9 with different data in the same cycle -> two sequential writes in grant order; the last write present on rf_write_data is from requester 2.
